// File: rtl/systolic_feeder.sv
// Skews two buffered N x N matrices into a systolic array: row i of X and column j of W
// enter lane i/j delayed by i/j steps. Define SYSTOLIC_FEEDER_WT_EN for column-wise W writes.
module systolic_feeder_lane #(
  parameter int N    = 4,
  parameter int DW   = 8,
  parameter int LANE = 0,
  parameter int SW   = 4
) (
  input  logic [SW-1:0]         step_i,
  input  logic [N-1:0][DW-1:0]  row_i,
  input  logic [N-1:0][DW-1:0]  col_i,
  output logic [DW-1:0]         x_o,
  output logic [DW-1:0]         w_o
);
  localparam int IW = $clog2(N);
  logic [SW-1:0] diff;
  logic          hit;

  always_comb begin
    diff = step_i - SW'(LANE);
    hit  = (step_i >= SW'(LANE)) && (diff < SW'(N));
    x_o  = '0;
    w_o  = '0;
    if (hit) begin
      x_o = row_i[diff[IW-1:0]];
      w_o = col_i[diff[IW-1:0]];
    end
  end
endmodule

module systolic_feeder #(
  parameter int N  = 4,
  parameter int DW = 8
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   wr_en,
  input  logic                   wr_sel,
  input  logic [$clog2(N)-1:0]   wr_row,
  input  logic [N-1:0][DW-1:0]   wr_data,
  input  logic                   go,
  input  logic                   stall,
  output logic [N-1:0][DW-1:0]   x_out,
  output logic [N-1:0][DW-1:0]   w_out,
  output logic                   start_out,
  output logic                   busy,
  output logic                   done
);
  localparam int SW = $clog2(3*N);

  typedef enum logic [1:0] {IDLE, FEED, FLUSH, DONE} state_t;

  state_t                          state_q;
  logic [SW-1:0]                   s_q, step_nxt;
  logic [N-1:0][N-1:0][DW-1:0]     xb_q, xb_d, wb_q, wb_d;
  logic [N-1:0][DW-1:0]            x_q, w_q, lane_x, lane_w;
  logic                            start_q, busy_q, done_q;

  // Buffers only accept writes in IDLE; lanes read the post-write view so a
  // write coincident with go is already visible at step 0.
  always_comb begin
    xb_d = xb_q;
    wb_d = wb_q;
    if (wr_en && state_q == IDLE) begin
      if (!wr_sel) xb_d[wr_row] = wr_data;
      else begin
`ifdef SYSTOLIC_FEEDER_WT_EN
        for (int k = 0; k < N; k++) wb_d[k][wr_row] = wr_data[k];
`else
        wb_d[wr_row] = wr_data;
`endif
      end
    end
  end

  assign step_nxt = (state_q == IDLE) ? '0 : s_q + SW'(1);

  for (genvar j = 0; j < N; j++) begin : g_lane
    logic [N-1:0][DW-1:0] wcol;
    for (genvar r = 0; r < N; r++) begin : g_col
      assign wcol[r] = wb_d[r][j];
    end
    systolic_feeder_lane #(.N(N), .DW(DW), .LANE(j), .SW(SW)) u_lane (
      .step_i (step_nxt),
      .row_i  (xb_d[j]),
      .col_i  (wcol),
      .x_o    (lane_x[j]),
      .w_o    (lane_w[j])
    );
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      s_q     <= '0;
      xb_q    <= '0;
      wb_q    <= '0;
      x_q     <= '0;
      w_q     <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      xb_q <= xb_d;
      wb_q <= wb_d;
      case (state_q)
        IDLE: if (go) begin
          state_q <= FEED;
          s_q     <= '0;
          x_q     <= lane_x;
          w_q     <= lane_w;
          start_q <= 1'b1;
          busy_q  <= 1'b1;
        end
        FEED: if (!stall) begin
          s_q     <= step_nxt;
          x_q     <= lane_x;
          w_q     <= lane_w;
          start_q <= 1'b0;
          if (s_q == SW'(2*N-2)) state_q <= FLUSH;
        end
        FLUSH: if (!stall) begin
          if (s_q == SW'(3*N-2)) begin
            state_q <= DONE;
            s_q     <= '0;
            x_q     <= '0;
            w_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            s_q <= step_nxt;
            x_q <= lane_x;
            w_q <= lane_w;
          end
        end
        default: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign x_out     = x_q;
  assign w_out     = w_q;
  assign start_out = start_q;
  assign busy      = busy_q;
  assign done      = done_q;
endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder (N=4, 8-bit words): skew pattern, stall, ignored go/write, reset abort.
module tb_systolic_feeder;
  localparam int N  = 4;
  localparam int DW = 8;

  logic                 clk = 1'b0;
  logic                 n_rst = 1'b1;
  logic                 wr_en = 1'b0, wr_sel = 1'b0, go = 1'b0, stall = 1'b0;
  logic [1:0]           wr_row = '0;
  logic [N-1:0][DW-1:0] wr_data = '0;
  logic [N-1:0][DW-1:0] x_out, w_out;
  logic                 start_out, busy, done;

  int          tests = 0, fails = 0;
  logic [31:0] ex [0:10];
  logic [31:0] ew [0:10];
  logic        done_seen;

  systolic_feeder #(.N(N), .DW(DW)) dut (
    .clk(clk), .n_rst(n_rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_row(wr_row),
    .wr_data(wr_data), .go(go), .stall(stall), .x_out(x_out), .w_out(w_out),
    .start_out(start_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic sel, input int row, input logic [31:0] d);
    wr_en = 1'b1; wr_sel = sel; wr_row = row[1:0]; wr_data = d;
    tick;
    wr_en = 1'b0;
  endtask

  // X = identity, W[r][c] = 4r+c+1
  task automatic load_std;
    logic [31:0] d;
    for (int r = 0; r < N; r++) wr(1'b0, r, 32'h1 << (8*r));
    for (int a = 0; a < N; a++) begin
      for (int k = 0; k < N; k++) begin
`ifdef SYSTOLIC_FEEDER_WT_EN
        d[8*k +: 8] = 8'(4*k + a + 1);
`else
        d[8*k +: 8] = 8'(4*a + k + 1);
`endif
      end
      wr(1'b1, a, d);
    end
  endtask

  task automatic std_tables;
    ex[0] = 32'h00000001; ew[0] = 32'h00000001;
    ex[1] = 32'h00000000; ew[1] = 32'h00000205;
    ex[2] = 32'h00000100; ew[2] = 32'h00030609;
    ex[3] = 32'h00000000; ew[3] = 32'h04070a0d;
    ex[4] = 32'h00010000; ew[4] = 32'h080b0e00;
    ex[5] = 32'h00000000; ew[5] = 32'h0c0f0000;
    ex[6] = 32'h01000000; ew[6] = 32'h10000000;
    for (int s = 7; s <= 10; s++) begin ex[s] = '0; ew[s] = '0; end
  endtask

  task automatic zero_tables;
    for (int s = 0; s <= 10; s++) begin ex[s] = '0; ew[s] = '0; end
  endtask

  // Streams one run, checking every step against the tables; optional stall
  // window at stall_s and an ignored go+X-write poke at poke_s.
  task automatic run_stream(input string tag, input int stall_s, input int stall_n, input int poke_s);
    int   s, held, cyc;
    logic st;
    s = 0; held = 0; cyc = 0;
    go = 1'b1;
    tick;
    go = 1'b0;
    while (s < 3*N-1 && cyc < 60) begin
      chk({tag, "_x"}, x_out, ex[s]);
      chk({tag, "_w"}, w_out, ew[s]);
      chk1({tag, "_start"}, start_out, s == 0);
      chk1({tag, "_busy"}, busy, 1'b1);
      chk1({tag, "_done_early"}, done, 1'b0);
      st = (s == stall_s) && (held < stall_n);
      stall = st;
      if (s == poke_s) begin
        go = 1'b1; wr_en = 1'b1; wr_sel = 1'b0; wr_row = 2'd0; wr_data = 32'h09090909;
      end
      tick;
      cyc++;
      stall = 1'b0; go = 1'b0; wr_en = 1'b0;
      if (st) held++; else s++;
    end
    chk1({tag, "_done"}, done, 1'b1);
    chk({tag, "_latency"}, 32'(cyc), 32'(3*N-1+stall_n));
    chk1({tag, "_busy_done"}, busy, 1'b0);
    chk({tag, "_x_done"}, x_out, 32'h0);
    go = 1'b1;
    tick;
    go = 1'b0;
    chk1({tag, "_done_pulse"}, done, 1'b0);
    chk1({tag, "_go_in_done"}, busy, 1'b0);
    tick;
    chk1({tag, "_idle"}, busy, 1'b0);
  endtask

  initial begin
    #2 n_rst = 1'b0;
    #1;
    chk("rst_x", x_out, 32'h0);
    chk("rst_w", w_out, 32'h0);
    chk1("rst_start", start_out, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    tick; tick;
    n_rst = 1'b1;
    tick;

    load_std;
    std_tables;
    run_stream("base", -1, 0, -1);
    run_stream("stall", 2, 3, -1);
    run_stream("poke", -1, 0, 3);
    run_stream("rerun", -1, 0, -1);

    // Reset mid-stream at s=4
    go = 1'b1;
    tick;
    go = 1'b0;
    for (int k = 0; k < 4; k++) tick;
    chk("pre_rst_x", x_out, ex[4]);
    chk("pre_rst_w", w_out, ew[4]);
    #2 n_rst = 1'b0;
    #1;
    chk("mid_rst_x", x_out, 32'h0);
    chk("mid_rst_w", w_out, 32'h0);
    chk1("mid_rst_busy", busy, 1'b0);
    chk1("mid_rst_done", done, 1'b0);
    done_seen = 1'b0;
    tick;
    n_rst = 1'b1;
    for (int k = 0; k < 15; k++) begin
      tick;
      if (done) done_seen = 1'b1;
    end
    chk1("rst_no_done", done_seen, 1'b0);
    chk1("rst_wait_idle", busy, 1'b0);
    zero_tables;
    run_stream("cleared", -1, 0, -1);

`ifdef SYSTOLIC_FEEDER_WT_EN
    wr(1'b1, 1, 32'h04030201);
    zero_tables;
    for (int s = 1; s <= 4; s++) ew[s] = 32'(s) << 8;
    run_stream("wt_col", -1, 0, -1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
